instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage of the multicycle datapath: owns the PC, issues word reads to instruction memory over req/ack,
//  latches the returned word into the instruction register, and presents decoded fields to control and datapath.
//  Its offs output drives the 16-bit input of the sign-extend stage directly downstream.
//  Supports PC redirect (branch/jump) with discard of any in-flight fetch.
// PARAMETERS
//  DW        32   instruction/data width (fields below assume 32)
//  AW        32   address width of PC and mem_addr
//  RESET_PC  0    PC value loaded on reset; must be word aligned
// PORTS
//  clk          in   1    rising-edge clock
//  rst_n        in   1    asynchronous reset, active low
//  mem_rd_req   out  1    read request to instruction memory, level, held until ack
//  mem_addr     out  AW   word address of request (= pc), stable while mem_rd_req=1
//  mem_rd_ack   in   1    one-cycle pulse: mem_rdata valid this cycle
//  mem_rdata    in   DW   instruction word from memory
//  ir_valid     out  1    IR holds an unconsumed instruction
//  ir_ready     in   1    control FSM accepts IR this cycle (consume when ir_valid & ir_ready)
//  pc_load      in   1    redirect pulse: next fetch from pc_target
//  pc_target    in   AW   redirect address
//  instr        out  DW   full IR contents
//  opcode       out  6    instr[31:26]
//  rs/rt/rd     out  5    instr[25:21]/[20:16]/[15:11]
//  funct        out  6    instr[5:0]
//  offs         out  16   instr[15:0], to sign-extend stage
//  pc_plus4     out  AW   address of instruction in IR + 4
//  align_err    out  1    one-cycle pulse: pc_target[1:0]!=0 on a pc_load
// BEHAVIOUR
//  States: IDLE, FETCH, HOLD. Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, instr=0, ir_valid=0,
//   pc_plus4=0, align_err=0, redirect_pend=0; mem_rd_req=0, mem_addr=RESET_PC.
//  IDLE: entered only from reset; -> FETCH on first clock edge after rst_n rises.
//  FETCH: mem_rd_req=1, mem_addr=pc (both decoded from registered state, no input->output comb path).
//   On mem_rd_ack & !redirect_pend & !pc_load: instr<=mem_rdata, pc_plus4<=pc+4, pc<=pc+4,
//   ir_valid<=1, ->HOLD. Ack in the same cycle FETCH is entered is legal (zero-wait memory).
//  HOLD: mem_rd_req=0; IR and fields stable. On ir_valid&ir_ready: ir_valid<=0, ->FETCH next cycle.
//  Latency: ack at cycle N -> ir_valid=1 at N+1; consume at M -> mem_rd_req=1 at M+1.
//   Peak throughput 1 instruction / 2 cycles.
//  Redirect (pc_load=1), target forced aligned: pc <= {pc_target[AW-1:2],2'b00}; align_err pulses if low bits !=0.
//   In HOLD: pc<=target, ir_valid<=0 (IR flushed, consumed or not), ->FETCH.
//   In FETCH, no ack this cycle: pc update deferred; redirect_pend<=1, target held;
//    mem_addr keeps old pc until ack (req/addr never change while outstanding).
//    On later ack: data discarded, pc<=held target, redirect_pend<=0, stay FETCH, new req next cycle.
//   In FETCH with ack same cycle: data discarded, pc<=target, stay FETCH (req drops 1 cycle, re-issues).
//   In IDLE: pc<=target; fetch proceeds from target.
//   pc_load while redirect_pend: newest target wins.
//  Arithmetic: pc+4 modulo 2^AW; wrap from 0xFFFFFFFC to 0 is legal, no flag.
//  mem_rd_ack outside FETCH ignored. Reset mid-fetch aborts request immediately; memory must drop it.
//  Field outputs are pure slices of instr (combinational from IR register).
// TESTING
//  Reset release, ack 2 cycles after req, rdata=0x8C22FFFC -> mem_addr=0, ir_valid 1 cycle after ack,
//   opcode=0x23, rs=1, rt=2, offs=0xFFFC, pc_plus4=4; next req addr=4 after ir_ready.
//  Zero-wait memory, ir_ready tied 1, 4 fetches -> addresses 0,4,8,12; ir_valid pulses every 2nd cycle.
//  HOLD with ir_ready=0 for 5 cycles -> IR, ir_valid, mem_rd_req=0 stable; no new req.
//  pc_load target=0x40 in FETCH 1 cycle before ack -> returned word not latched, ir_valid stays 0,
//   next req addr=0x40.
//  pc_load target=0x103 -> align_err pulse, next fetch addr=0x100; pc=0xFFFFFFFC fetch -> pc_plus4=0.
//  rst_n low mid-wait -> mem_rd_req=0 and ir_valid=0 immediately; restart fetch at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC and fetches words over req/ack into the IR.
// Supports redirects that discard any in-flight fetch.
module instr_fetch_unit #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          mem_rd_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_rd_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          ir_valid,
    input  logic          ir_ready,
    input  logic          pc_load,
    input  logic [AW-1:0] pc_target,
    output logic [DW-1:0] instr,
    output logic [5:0]    opcode,
    output logic [4:0]    rs,
    output logic [4:0]    rt,
    output logic [4:0]    rd,
    output logic [5:0]    funct,
    output logic [15:0]   offs,
    output logic [AW-1:0] pc_plus4,
    output logic          align_err
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
    state_t state, state_nx;
    logic [AW-1:0] pc, pc_nx, tgt, tgt_nx, tgt_al, p4_nx;
    logic [DW-1:0] instr_nx;
    logic valid_nx, redirect_pend, pend_nx, gap, gap_nx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc <= RESET_PC;
            tgt <= '0;
            instr <= '0;
            ir_valid <= 1'b0;
            pc_plus4 <= '0;
            align_err <= 1'b0;
            redirect_pend <= 1'b0;
            gap <= 1'b0;
        end else begin
            state <= state_nx;
            pc <= pc_nx;
            tgt <= tgt_nx;
            instr <= instr_nx;
            ir_valid <= valid_nx;
            pc_plus4 <= p4_nx;
            align_err <= pc_load && (pc_target[1:0] != 2'b00);
            redirect_pend <= pend_nx;
            gap <= gap_nx;
        end
    end
    // gap holds req low for one cycle after an ack that coincides with a redirect
    always_comb begin
        tgt_al = {pc_target[AW-1:2], 2'b00};
        state_nx = state;
        pc_nx = pc;
        tgt_nx = tgt;
        instr_nx = instr;
        valid_nx = ir_valid;
        p4_nx = pc_plus4;
        pend_nx = redirect_pend;
        gap_nx = 1'b0;
        case (state)
            IDLE: begin
                state_nx = FETCH;
                pc_nx = pc_load ? tgt_al : pc;
            end
            FETCH: begin
                if (gap) begin
                    pc_nx = pc_load ? tgt_al : pc;
                end else if (mem_rd_ack) begin
                    pend_nx = 1'b0;
                    if (pc_load) begin
                        pc_nx = tgt_al;
                        gap_nx = 1'b1;
                    end else if (redirect_pend) begin
                        pc_nx = tgt;
                    end else begin
                        instr_nx = mem_rdata;
                        pc_nx = pc + AW'(4);
                        p4_nx = pc + AW'(4);
                        valid_nx = 1'b1;
                        state_nx = HOLD;
                    end
                end else if (pc_load) begin
                    pend_nx = 1'b1;
                    tgt_nx = tgt_al;
                end
            end
            HOLD: begin
                if (pc_load || (ir_valid && ir_ready)) begin
                    valid_nx = 1'b0;
                    state_nx = FETCH;
                    pc_nx = pc_load ? tgt_al : pc;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
    assign mem_rd_req = (state == FETCH) && !gap;
    assign mem_addr = pc;
    assign opcode = instr[31:26];
    assign rs = instr[25:21];
    assign rt = instr[20:16];
    assign rd = instr[15:11];
    assign funct = instr[5:0];
    assign offs = instr[15:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: random and directed stimulus checked every cycle against a
// behavioural fetch model, plus literal expectations from hand-worked scenarios.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_rd_req, ir_valid, align_err;
    logic mem_rd_ack = 1'b0, ir_ready = 1'b0, pc_load = 1'b0;
    logic [31:0] mem_addr, instr, pc_plus4;
    logic [31:0] mem_rdata = '0, pc_target = '0;
    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;
    logic [15:0] offs;
    int checks = 0;
    int failures = 0;

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
        .mem_rd_ack(mem_rd_ack), .mem_rdata(mem_rdata), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .pc_load(pc_load), .pc_target(pc_target), .instr(instr),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .offs(offs),
        .pc_plus4(pc_plus4), .align_err(align_err)
    );

    always #5 clk = ~clk;

    // model phases: 0 after reset, 1 request outstanding, 2 holding word, 3 one-cycle bubble
    int m_phase;
    logic [31:0] m_pc, m_instr, m_p4, m_redir;
    logic m_redir_v, m_valid, m_aerr;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endtask

    task automatic check_all();
        chk("req", 32'(mem_rd_req), 32'(m_phase == 1));
        chk("addr", mem_addr, m_pc);
        chk("ir_valid", 32'(ir_valid), 32'(m_valid));
        chk("instr", instr, m_instr);
        chk("opcode", 32'(opcode), 32'(m_instr[31:26]));
        chk("rs", 32'(rs), 32'(m_instr[25:21]));
        chk("rt", 32'(rt), 32'(m_instr[20:16]));
        chk("rd", 32'(rd), 32'(m_instr[15:11]));
        chk("funct", 32'(funct), 32'(m_instr[5:0]));
        chk("offs", 32'(offs), 32'(m_instr[15:0]));
        chk("pc_plus4", pc_plus4, m_p4);
        chk("align_err", 32'(align_err), 32'(m_aerr));
    endtask

    task automatic model_reset();
        m_phase = 0; m_pc = '0; m_instr = '0; m_p4 = '0;
        m_valid = 1'b0; m_aerr = 1'b0; m_redir_v = 1'b0; m_redir = '0;
    endtask

    task automatic model_step();
        logic [31:0] t;
        t = pc_target & 32'hFFFF_FFFC;
        m_aerr = pc_load && (pc_target[1:0] != 2'b00);
        if (m_phase == 0 || m_phase == 3) begin
            if (pc_load) m_pc = t;
            m_phase = 1;
        end else if (m_phase == 2) begin
            if (pc_load || ir_ready) begin
                if (pc_load) m_pc = t;
                m_valid = 1'b0;
                m_phase = 1;
            end
        end else if (mem_rd_ack) begin
            if (pc_load) begin
                m_pc = t; m_redir_v = 1'b0; m_phase = 3;
            end else if (m_redir_v) begin
                m_pc = m_redir; m_redir_v = 1'b0;
            end else begin
                m_instr = mem_rdata; m_pc = m_pc + 32'd4; m_p4 = m_pc;
                m_valid = 1'b1; m_phase = 2;
            end
        end else if (pc_load) begin
            m_redir_v = 1'b1; m_redir = t;
        end
    endtask

    task automatic tick(input logic ack, input logic [31:0] rdat, input logic rdy,
                        input logic ld, input logic [31:0] tg);
        mem_rd_ack = ack; mem_rdata = rdat; ir_ready = rdy; pc_load = ld; pc_target = tg;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        mem_rd_ack = 1'b0; ir_ready = 1'b0; pc_load = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_req", 32'(mem_rd_req), 32'd0);
        chk("rst_valid", 32'(ir_valid), 32'd0);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        model_reset();
        @(negedge clk);
        do_reset();
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_p4", pc_plus4, 32'h0);
        // first fetch with two wait cycles
        tick(0, 0, 0, 0, 0);
        chk("a_req", 32'(mem_rd_req), 32'd1);
        chk("a_addr", mem_addr, 32'h0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(1, 32'h8C22_FFFC, 0, 0, 0);
        chk("a_valid", 32'(ir_valid), 32'd1);
        chk("a_opcode", 32'(opcode), 32'h23);
        chk("a_rs", 32'(rs), 32'd1);
        chk("a_rt", 32'(rt), 32'd2);
        chk("a_offs", 32'(offs), 32'hFFFC);
        chk("a_p4", pc_plus4, 32'd4);
        chk("a_req_hold", 32'(mem_rd_req), 32'd0);
        tick(0, 0, 1, 0, 0);
        chk("a_next_addr", mem_addr, 32'd4);
        chk("a_next_req", 32'(mem_rd_req), 32'd1);
        // zero-wait memory, always ready
        do_reset();
        tick(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                chk("b_req", 32'(mem_rd_req), 32'd1);
                chk("b_addr", mem_addr, 32'(4 * (i / 2)));
                chk("b_valid0", 32'(ir_valid), 32'd0);
                tick(1, 32'(i), 1, 0, 0);
            end else begin
                chk("b_valid1", 32'(ir_valid), 32'd1);
                tick(0, 0, 1, 0, 0);
            end
        end
        // stall in HOLD
        chk("c_addr", mem_addr, 32'd16);
        tick(1, 32'h1234_5678, 0, 0, 0);
        repeat (5) begin
            chk("c_req", 32'(mem_rd_req), 32'd0);
            chk("c_valid", 32'(ir_valid), 32'd1);
            chk("c_instr", instr, 32'h1234_5678);
            tick(0, 0, 0, 0, 0);
        end
        tick(0, 0, 1, 0, 0);
        // redirect one cycle before ack
        tick(0, 0, 0, 1, 32'h40);
        chk("d_addr_held", mem_addr, 32'd20);
        tick(1, 32'hDEAD_BEEF, 0, 0, 0);
        chk("d_valid", 32'(ir_valid), 32'd0);
        chk("d_req", 32'(mem_rd_req), 32'd1);
        chk("d_addr", mem_addr, 32'h40);
        chk("d_instr", instr, 32'h1234_5678);
        // misaligned target, then redirect with ack in the same cycle
        tick(0, 0, 0, 1, 32'h103);
        chk("e_aerr", 32'(align_err), 32'd1);
        tick(1, 0, 0, 0, 0);
        chk("e_aerr_off", 32'(align_err), 32'd0);
        chk("e_addr", mem_addr, 32'h100);
        tick(1, 32'h55, 0, 1, 32'h200);
        chk("e_gap_req", 32'(mem_rd_req), 32'd0);
        chk("e_gap_valid", 32'(ir_valid), 32'd0);
        tick(0, 0, 0, 0, 0);
        chk("e_reissue", mem_addr, 32'h200);
        // wrap of pc+4
        tick(0, 0, 0, 1, 32'hFFFF_FFFC);
        tick(1, 0, 0, 0, 0);
        chk("e_top_addr", mem_addr, 32'hFFFF_FFFC);
        tick(1, 32'hABCD_0000, 0, 0, 0);
        chk("e_wrap_p4", pc_plus4, 32'h0);
        tick(0, 0, 1, 0, 0);
        chk("e_wrap_addr", mem_addr, 32'h0);
        // reset while waiting, then reset while holding
        tick(0, 0, 0, 0, 0);
        #2;
        do_reset();
        tick(0, 0, 0, 0, 0);
        tick(1, 32'h7777_0001, 0, 0, 0);
        chk("f_valid", 32'(ir_valid), 32'd1);
        #2;
        do_reset();
        tick(0, 0, 0, 0, 0);
        chk("f_addr", mem_addr, 32'h0);
        // randomized traffic
        cnt = -1;
        for (int i = 0; i < 3000; i++) begin
            logic a;
            logic [31:0] tg;
            a = 1'b0;
            if (mem_rd_req) begin
                if (cnt < 0) cnt = int'($urandom_range(0, 3));
                if (cnt == 0) begin
                    a = 1'b1;
                    cnt = -1;
                end else cnt--;
            end else begin
                cnt = -1;
                a = ($urandom_range(0, 19) == 0);
            end
            tg = $urandom_range(0, 1) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
            tick(a, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0, tg);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
